// File: rtl/load_store_queue.sv
// load_store_queue: in-order load/store queue feeding the dmem stage.
// Dispatched memory ops wait in a circular buffer for their base and
// store-data operands (snooped from the CDB) and for branch resolution.
// The head entry is presented combinationally on the lsu_* outputs.
// cdb_i is packed as {tag[TAG_W-1:0], val[31:0]}; a tag of NO_VAL marks idle.
// Optional feature macro: LSQ_CDB_BYPASS_EN -- when defined, a dispatched
// operand whose tag matches the CDB in the same cycle is written as ready.
module load_store_queue #(
    parameter int unsigned       DEPTH  = 8,
    parameter int unsigned       TAG_W  = 5,
    parameter logic [TAG_W-1:0]  NO_VAL = '0
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              disp_valid_i,
    input  logic              disp_load_i,
    input  logic [TAG_W-1:0]  disp_base_tag_i,
    input  logic [31:0]       disp_base_val_i,
    input  logic [TAG_W-1:0]  disp_data_tag_i,
    input  logic [31:0]       disp_data_val_i,
    input  logic [31:0]       disp_offset_i,
    input  logic [TAG_W-1:0]  disp_ld_tag_i,
    input  logic              disp_spec_i,
    output logic              disp_full_o,
    input  logic [TAG_W+31:0] cdb_i,
    input  logic              br_resolve_i,
    input  logic              br_correct_i,
    output logic              lsu_empty_o,
    output logic [31:0]       lsu_eff_addr_o,
    output logic [31:0]       lsu_st_data_o,
    output logic [TAG_W-1:0]  lsu_ld_tag_o,
    output logic              lsu_load_o,
    output logic              lsu_instr_ready_o,
    output logic              lsu_specultative_o,
    output logic              lsu_corr_pred_o,
    input  logic              lsu_read_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             valid_q    [DEPTH];
    logic             valid_d    [DEPTH];
    logic             load_q     [DEPTH];
    logic             load_d     [DEPTH];
    logic [TAG_W-1:0] base_tag_q [DEPTH];
    logic [TAG_W-1:0] base_tag_d [DEPTH];
    logic [31:0]      base_val_q [DEPTH];
    logic [31:0]      base_val_d [DEPTH];
    logic [TAG_W-1:0] data_tag_q [DEPTH];
    logic [TAG_W-1:0] data_tag_d [DEPTH];
    logic [31:0]      data_val_q [DEPTH];
    logic [31:0]      data_val_d [DEPTH];
    logic [31:0]      offset_q   [DEPTH];
    logic [31:0]      offset_d   [DEPTH];
    logic [TAG_W-1:0] ld_tag_q   [DEPTH];
    logic [TAG_W-1:0] ld_tag_d   [DEPTH];
    logic             spec_q     [DEPTH];
    logic             spec_d     [DEPTH];
    logic             res_q      [DEPTH];
    logic             res_d      [DEPTH];
    logic             corr_q     [DEPTH];
    logic             corr_d     [DEPTH];

    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_val;
    logic             cdb_live;
    logic             do_push, do_pop;

    assign cdb_tag  = cdb_i[TAG_W+31:32];
    assign cdb_val  = cdb_i[31:0];
    assign cdb_live = (cdb_tag != NO_VAL);

    // Full is taken from the registered count, so a pop never frees a slot the same cycle.
    assign disp_full_o = (count_q == CNT_W'(DEPTH));
    assign do_push     = disp_valid_i & ~disp_full_o;
    assign do_pop      = lsu_read_i & valid_q[head_q];

    // Next-state: CDB snoop, branch resolution, pop and dispatch for every entry.
    always_comb begin
        valid_d    = valid_q;
        load_d     = load_q;
        base_tag_d = base_tag_q;
        base_val_d = base_val_q;
        data_tag_d = data_tag_q;
        data_val_d = data_val_q;
        offset_d   = offset_q;
        ld_tag_d   = ld_tag_q;
        spec_d     = spec_q;
        res_d      = res_q;
        corr_d     = corr_q;
        head_d     = head_q;
        tail_d     = tail_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                if (cdb_live && base_tag_q[i] == cdb_tag) begin
                    base_tag_d[i] = NO_VAL;
                    base_val_d[i] = cdb_val;
                end
                if (cdb_live && data_tag_q[i] == cdb_tag) begin
                    data_tag_d[i] = NO_VAL;
                    data_val_d[i] = cdb_val;
                end
                if (br_resolve_i && spec_q[i]) begin
                    res_d[i]  = 1'b1;
                    corr_d[i] = br_correct_i;
                end
            end
        end

        if (do_pop) begin
            valid_d[head_q] = 1'b0;
            head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
        end

        if (do_push) begin
            valid_d[tail_q]    = 1'b1;
            load_d[tail_q]     = disp_load_i;
            base_tag_d[tail_q] = disp_base_tag_i;
            base_val_d[tail_q] = disp_base_val_i;
            data_tag_d[tail_q] = disp_load_i ? NO_VAL : disp_data_tag_i;
            data_val_d[tail_q] = disp_load_i ? '0 : disp_data_val_i;
            offset_d[tail_q]   = disp_offset_i;
            ld_tag_d[tail_q]   = disp_load_i ? disp_ld_tag_i : NO_VAL;
            spec_d[tail_q]     = disp_spec_i;
            res_d[tail_q]      = disp_spec_i & br_resolve_i;
            corr_d[tail_q]     = disp_spec_i & br_resolve_i & br_correct_i;
`ifdef LSQ_CDB_BYPASS_EN
            if (cdb_live && disp_base_tag_i == cdb_tag) begin
                base_tag_d[tail_q] = NO_VAL;
                base_val_d[tail_q] = cdb_val;
            end
            if (cdb_live && !disp_load_i && disp_data_tag_i == cdb_tag) begin
                data_tag_d[tail_q] = NO_VAL;
                data_val_d[tail_q] = cdb_val;
            end
`endif
            tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // State registers; asynchronous reset discards every entry.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '{default: '0};
            load_q     <= '{default: '0};
            base_tag_q <= '{default: '0};
            base_val_q <= '{default: '0};
            data_tag_q <= '{default: '0};
            data_val_q <= '{default: '0};
            offset_q   <= '{default: '0};
            ld_tag_q   <= '{default: '0};
            spec_q     <= '{default: '0};
            res_q      <= '{default: '0};
            corr_q     <= '{default: '0};
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            load_q     <= load_d;
            base_tag_q <= base_tag_d;
            base_val_q <= base_val_d;
            data_tag_q <= data_tag_d;
            data_val_q <= data_val_d;
            offset_q   <= offset_d;
            ld_tag_q   <= ld_tag_d;
            spec_q     <= spec_d;
            res_q      <= res_d;
            corr_q     <= corr_d;
        end
    end

    logic h_valid, h_ops_rdy, h_spec, h_res, h_corr;

    // Head presentation; everything is gated by head valid so an empty queue shows idle values.
    always_comb begin
        h_valid   = valid_q[head_q];
        h_spec    = spec_q[head_q];
        h_res     = res_q[head_q];
        h_corr    = corr_q[head_q];
        h_ops_rdy = (base_tag_q[head_q] == NO_VAL) &
                    (load_q[head_q] | (data_tag_q[head_q] == NO_VAL));

        lsu_empty_o        = ~h_valid;
        lsu_eff_addr_o     = h_valid ? base_val_q[head_q] + offset_q[head_q] : '0;
        lsu_st_data_o      = h_valid ? data_val_q[head_q] : '0;
        lsu_ld_tag_o       = (h_valid & load_q[head_q]) ? ld_tag_q[head_q] : NO_VAL;
        lsu_load_o         = h_valid & load_q[head_q];
        // Squashed heads are ready regardless of operands so the dmem stage can drop them.
        lsu_instr_ready_o  = h_valid & ((h_ops_rdy & (~h_spec | (h_res & h_corr)))
                                       | (h_spec & h_res & ~h_corr));
        lsu_specultative_o = h_valid & h_spec & ~(h_res & h_corr);
        lsu_corr_pred_o    = h_valid & h_res & h_corr;
    end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed self-checking bench for load_store_queue (DEPTH=8, TAG_W=5, NO_VAL=0).
// Stimulus never presents a CDB tag in the same cycle as the matching dispatch,
// so expectations hold with and without LSQ_CDB_BYPASS_EN.
module tb_load_store_queue;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        disp_valid_i = 1'b0;
    logic        disp_load_i = 1'b0;
    logic [4:0]  disp_base_tag_i = '0;
    logic [31:0] disp_base_val_i = '0;
    logic [4:0]  disp_data_tag_i = '0;
    logic [31:0] disp_data_val_i = '0;
    logic [31:0] disp_offset_i = '0;
    logic [4:0]  disp_ld_tag_i = '0;
    logic        disp_spec_i = 1'b0;
    logic        disp_full_o;
    logic [36:0] cdb_i = '0;
    logic        br_resolve_i = 1'b0;
    logic        br_correct_i = 1'b0;
    logic        lsu_empty_o;
    logic [31:0] lsu_eff_addr_o;
    logic [31:0] lsu_st_data_o;
    logic [4:0]  lsu_ld_tag_o;
    logic        lsu_load_o;
    logic        lsu_instr_ready_o;
    logic        lsu_specultative_o;
    logic        lsu_corr_pred_o;
    logic        lsu_read_i = 1'b0;

    int checks = 0;
    int errors = 0;

    load_store_queue #(.DEPTH(8), .TAG_W(5), .NO_VAL(5'd0)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .disp_valid_i(disp_valid_i), .disp_load_i(disp_load_i),
        .disp_base_tag_i(disp_base_tag_i), .disp_base_val_i(disp_base_val_i),
        .disp_data_tag_i(disp_data_tag_i), .disp_data_val_i(disp_data_val_i),
        .disp_offset_i(disp_offset_i), .disp_ld_tag_i(disp_ld_tag_i),
        .disp_spec_i(disp_spec_i), .disp_full_o(disp_full_o), .cdb_i(cdb_i),
        .br_resolve_i(br_resolve_i), .br_correct_i(br_correct_i),
        .lsu_empty_o(lsu_empty_o), .lsu_eff_addr_o(lsu_eff_addr_o),
        .lsu_st_data_o(lsu_st_data_o), .lsu_ld_tag_o(lsu_ld_tag_o),
        .lsu_load_o(lsu_load_o), .lsu_instr_ready_o(lsu_instr_ready_o),
        .lsu_specultative_o(lsu_specultative_o), .lsu_corr_pred_o(lsu_corr_pred_o),
        .lsu_read_i(lsu_read_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_disp(input logic ld, input logic [4:0] btag, input logic [31:0] bval,
                            input logic [4:0] dtag, input logic [31:0] dval,
                            input logic [31:0] off, input logic [4:0] ldtag, input logic sp);
        disp_valid_i = 1'b1;  disp_load_i = ld;
        disp_base_tag_i = btag; disp_base_val_i = bval;
        disp_data_tag_i = dtag; disp_data_val_i = dval;
        disp_offset_i = off;  disp_ld_tag_i = ldtag; disp_spec_i = sp;
    endtask

    task automatic disp(input logic ld, input logic [4:0] btag, input logic [31:0] bval,
                        input logic [4:0] dtag, input logic [31:0] dval,
                        input logic [31:0] off, input logic [4:0] ldtag, input logic sp);
        set_disp(ld, btag, bval, dtag, dval, off, ldtag, sp);
        step();
        disp_valid_i = 1'b0;
    endtask

    task automatic pop();
        lsu_read_i = 1'b1;
        step();
        lsu_read_i = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] val);
        cdb_i = {tag, val};
        step();
        cdb_i = '0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_empty"}, 32'(lsu_empty_o), 32'd1);
        chk({tag, "_full"},  32'(disp_full_o), 32'd0);
        chk({tag, "_ready"}, 32'(lsu_instr_ready_o), 32'd0);
        chk({tag, "_load"},  32'(lsu_load_o), 32'd0);
        chk({tag, "_spec"},  32'(lsu_specultative_o), 32'd0);
        chk({tag, "_corr"},  32'(lsu_corr_pred_o), 32'd0);
        chk({tag, "_ldtag"}, 32'(lsu_ld_tag_o), 32'd0);
        chk({tag, "_addr"},  lsu_eff_addr_o, 32'd0);
        chk({tag, "_data"},  lsu_st_data_o, 32'd0);
    endtask

    initial begin
        // Reset
        #22;
        chk_idle("rst");
        reset_ni = 1'b1;
        step();

        // 1: single ready load
        disp(1'b1, 5'd0, 32'h1000, 5'd0, 32'h0, 32'h10, 5'd3, 1'b0);
        chk("t1_empty", 32'(lsu_empty_o), 32'd0);
        chk("t1_ready", 32'(lsu_instr_ready_o), 32'd1);
        chk("t1_addr", lsu_eff_addr_o, 32'h1010);
        chk("t1_load", 32'(lsu_load_o), 32'd1);
        chk("t1_ldtag", 32'(lsu_ld_tag_o), 32'd3);
        pop();
        chk("t1_pop_empty", 32'(lsu_empty_o), 32'd1);
        pop();
        chk("t1_pop_while_empty", 32'(lsu_empty_o), 32'd1);
        chk("t1_pop_while_empty_full", 32'(disp_full_o), 32'd0);

        // 2: store waits for base then data from CDB
        disp(1'b0, 5'd5, 32'hDEAD, 5'd6, 32'h0, 32'h8, 5'd9, 1'b0);
        chk("t2_ready0", 32'(lsu_instr_ready_o), 32'd0);
        chk("t2_load", 32'(lsu_load_o), 32'd0);
        chk("t2_ldtag", 32'(lsu_ld_tag_o), 32'd0);
        cdb(5'd5, 32'h200);
        chk("t2_ready1", 32'(lsu_instr_ready_o), 32'd0);
        chk("t2_addr", lsu_eff_addr_o, 32'h208);
        cdb(5'd6, 32'hAB);
        chk("t2_ready2", 32'(lsu_instr_ready_o), 32'd1);
        chk("t2_data", lsu_st_data_o, 32'hAB);
        chk("t2_addr2", lsu_eff_addr_o, 32'h208);
        pop();
        chk("t2_empty", 32'(lsu_empty_o), 32'd1);

        // 3: fill, overflow drop, pop+dispatch while full, drain in order
        for (int i = 1; i <= 8; i++) begin
            chk("t3_notfull", 32'(disp_full_o), 32'd0);
            disp(1'b0, 5'd0, 32'(i * 32'h100), 5'd0, 32'(i), 32'h0, 5'd0, 1'b0);
        end
        chk("t3_full", 32'(disp_full_o), 32'd1);
        disp(1'b0, 5'd0, 32'h900, 5'd0, 32'h9, 32'h0, 5'd0, 1'b0);
        chk("t3_full_after_drop", 32'(disp_full_o), 32'd1);
        chk("t3_head_after_drop", lsu_eff_addr_o, 32'h100);
        set_disp(1'b0, 5'd0, 32'hA00, 5'd0, 32'hA, 32'h0, 5'd0, 1'b0);
        lsu_read_i = 1'b1;
        step();
        lsu_read_i = 1'b0;
        disp_valid_i = 1'b0;
        chk("t3_count7_notfull", 32'(disp_full_o), 32'd0);
        for (int i = 2; i <= 8; i++) begin
            chk("t3_order_addr", lsu_eff_addr_o, 32'(i * 32'h100));
            chk("t3_order_data", lsu_st_data_o, 32'(i));
            pop();
        end
        chk("t3_drained", 32'(lsu_empty_o), 32'd1);
        for (int k = 0; k < 20; k++) begin
            set_disp(1'b0, 5'd0, 32'h4000 + 32'(k), 5'd0, 32'h50 + 32'(k), 32'h0, 5'd0, 1'b0);
            lsu_read_i = (k > 0);
            step();
            chk("t3_stream_addr", lsu_eff_addr_o, 32'h4000 + 32'(k));
            chk("t3_stream_data", lsu_st_data_o, 32'h50 + 32'(k));
        end
        disp_valid_i = 1'b0;
        pop();
        chk("t3_stream_empty", 32'(lsu_empty_o), 32'd1);

        // 4: spec load waits for a correct resolve; address wraps mod 2^32
        disp(1'b1, 5'd0, 32'hFFFF_FFF0, 5'd0, 32'h0, 32'h20, 5'd7, 1'b1);
        chk("t4_ready0", 32'(lsu_instr_ready_o), 32'd0);
        chk("t4_spec0", 32'(lsu_specultative_o), 32'd1);
        chk("t4_corr0", 32'(lsu_corr_pred_o), 32'd0);
        chk("t4_addr_wrap", lsu_eff_addr_o, 32'h10);
        br_resolve_i = 1'b1; br_correct_i = 1'b1;
        step();
        br_resolve_i = 1'b0; br_correct_i = 1'b0;
        chk("t4_ready1", 32'(lsu_instr_ready_o), 32'd1);
        chk("t4_spec1", 32'(lsu_specultative_o), 32'd0);
        chk("t4_corr1", 32'(lsu_corr_pred_o), 32'd1);
        pop();
        chk("t4_empty", 32'(lsu_empty_o), 32'd1);

        // 5: mispredict squashes two pending spec ops; non-spec op behind still waits
        disp(1'b1, 5'd9, 32'h0, 5'd0, 32'h0, 32'h4, 5'd2, 1'b1);
        disp(1'b0, 5'd0, 32'h600, 5'd10, 32'h0, 32'h0, 5'd0, 1'b1);
        disp(1'b1, 5'd11, 32'h0, 5'd0, 32'h0, 32'h8, 5'd4, 1'b0);
        chk("t5_ready_pre", 32'(lsu_instr_ready_o), 32'd0);
        br_resolve_i = 1'b1; br_correct_i = 1'b0;
        step();
        br_resolve_i = 1'b0;
        chk("t5_a_ready", 32'(lsu_instr_ready_o), 32'd1);
        chk("t5_a_spec", 32'(lsu_specultative_o), 32'd1);
        chk("t5_a_corr", 32'(lsu_corr_pred_o), 32'd0);
        chk("t5_a_load", 32'(lsu_load_o), 32'd1);
        pop();
        chk("t5_b_ready", 32'(lsu_instr_ready_o), 32'd1);
        chk("t5_b_spec", 32'(lsu_specultative_o), 32'd1);
        chk("t5_b_load", 32'(lsu_load_o), 32'd0);
        pop();
        chk("t5_c_empty", 32'(lsu_empty_o), 32'd0);
        chk("t5_c_ready", 32'(lsu_instr_ready_o), 32'd0);
        chk("t5_c_spec", 32'(lsu_specultative_o), 32'd0);
        cdb(5'd11, 32'h50);
        chk("t5_c_ready2", 32'(lsu_instr_ready_o), 32'd1);
        chk("t5_c_addr", lsu_eff_addr_o, 32'h58);
        chk("t5_c_ldtag", 32'(lsu_ld_tag_o), 32'd4);
        pop();
        chk("t5_empty", 32'(lsu_empty_o), 32'd1);

        // 6: asynchronous reset with four entries in flight
        for (int i = 0; i < 4; i++)
            disp(1'b1, 5'd0, 32'h7000 + 32'(i), 5'd0, 32'h0, 32'h0, 5'(i + 1), 1'b0);
        chk("t6_ready_pre", 32'(lsu_instr_ready_o), 32'd1);
        #2;
        reset_ni = 1'b0;
        #1;
        chk_idle("t6_async");
        #3;
        reset_ni = 1'b1;
        step();
        chk("t6_still_empty", 32'(lsu_empty_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
